// File: rtl/ram_rd_stream.sv
// ram_rd_stream: streams a contiguous, wrapping address range out of a
// synchronous-read RAM port (1-cycle read latency) as a valid/ready stream
// with full backpressure and one word per cycle.
//
// Optional feature: define RAM_RD_STREAM_ABORT_EN to add an 'abort' input
// that cancels a running command, flushes buffered and in-flight words and
// finishes with a single done pulse.
//
// Buffering: the registered output stage plus a 2-entry FIFO behind it give
// three word slots, which covers the two-stage RAM round trip so the stream
// runs without bubbles. A read is issued only if the words already owned
// (output register, FIFO, both RAM pipeline stages) minus this cycle's pop
// leave a free slot, so no word can ever be dropped under backpressure.

module ram_rd_stream #(
  parameter int Width = 18,
  parameter int Depth = 64
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef RAM_RD_STREAM_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     start,
  input  logic [$clog2(Depth)-1:0] start_addr,
  input  logic [$clog2(Depth):0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(Depth)-1:0] ram_rd_addr,
  input  logic [Width-1:0]         ram_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Width-1:0]         out_data,
  output logic                     out_last
);

  localparam int AddrBits = $clog2(Depth);
  localparam logic [AddrBits-1:0] AddrOne  = AddrBits'(1);
  localparam logic [AddrBits-1:0] AddrLast = AddrBits'(Depth - 1);
  localparam logic [AddrBits:0]   LenOne   = (AddrBits + 1)'(1);
  localparam logic [AddrBits:0]   LenMax   = (AddrBits + 1)'(Depth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [AddrBits-1:0]   ram_rd_addr_q;
  logic [AddrBits:0]     rem_q;        // reads still to issue after the current address
  logic                  iss_q;        // address on ram_rd_addr is a live read
  logic                  iss_last_q;
  logic                  rd_q;         // ram_rd_data carries a live word this cycle
  logic                  rd_last_q;

  logic                  out_valid_q, out_valid_d;
  logic [Width-1:0]      out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic [Width-1:0]      fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_wr_ptr_q;
  logic                  fifo_rd_ptr_q;
  logic [1:0]            fifo_cnt_q;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic                  pop;
  logic [2:0]            occupancy;
  logic                  issue_ok;
  logic                  drain_done;
  logic                  abort_hit;
  logic [AddrBits:0]     len_clamped;
  logic [AddrBits-1:0]   addr_inc;

`ifdef RAM_RD_STREAM_ABORT_EN
  // Abort is honoured only while a command is active and not yet finishing.
  assign abort_hit = abort & ((state_q == S_READ) | (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign pop         = out_valid_q & out_ready;
  assign occupancy   = 3'(out_valid_q) + 3'(fifo_cnt_q) + 3'(iss_q) + 3'(rd_q);
  assign issue_ok    = (occupancy - 3'(pop)) < 3'd3;
  assign drain_done  = (fifo_cnt_q == 2'd0) & ~iss_q & ~rd_q & (~out_valid_q | pop);
  assign len_clamped = (length > LenMax) ? LenMax : length;
  assign addr_inc    = (ram_rd_addr_q == AddrLast) ? '0 : ram_rd_addr_q + AddrOne;

  // Command FSM: accepts start, issues RAM reads under credit, tracks the read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ram_rd_addr_q <= '0;
      rem_q         <= '0;
      iss_q         <= 1'b0;
      iss_last_q    <= 1'b0;
      rd_q          <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      iss_q      <= 1'b0;
      iss_last_q <= 1'b0;
      rd_q       <= iss_q;
      rd_last_q  <= iss_last_q;
      if (abort_hit) begin
        // Drop the pipeline; DRAIN then sees everything empty and finishes next edge.
        state_q   <= S_DRAIN;
        rd_q      <= 1'b0;
        rd_last_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              busy_q        <= 1'b1;
              ram_rd_addr_q <= start_addr;
              if (len_clamped == '0) begin
                // Empty command: pass through DRAIN so done lands two cycles out.
                state_q <= S_DRAIN;
              end else begin
                iss_q      <= 1'b1;
                iss_last_q <= (len_clamped == LenOne);
                rem_q      <= len_clamped - LenOne;
                state_q    <= (len_clamped == LenOne) ? S_DRAIN : S_READ;
              end
            end
          end
          S_READ: begin
            if (issue_ok) begin
              iss_q         <= 1'b1;
              ram_rd_addr_q <= addr_inc;
              rem_q         <= rem_q - LenOne;
              iss_last_q    <= (rem_q == LenOne);
              if (rem_q == LenOne) begin
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (drain_done) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage steering: refill the output register from the FIFO first, else bypass RAM data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (abort_hit) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (!out_valid_q || pop) begin
      if (fifo_cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_data_q[fifo_rd_ptr_q];
        out_last_d  = fifo_last_q[fifo_rd_ptr_q];
        fifo_pop    = 1'b1;
        fifo_push   = rd_q;
      end else if (rd_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rd_data;
        out_last_d  = rd_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else begin
      // Stalled: output register holds, arriving data parks in the FIFO.
      fifo_push = rd_q;
    end
  end

  // Output register and 2-entry FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      if (abort_hit) begin
        fifo_wr_ptr_q <= 1'b0;
        fifo_rd_ptr_q <= 1'b0;
        fifo_cnt_q    <= 2'd0;
      end else begin
        if (fifo_push) begin
          fifo_data_q[fifo_wr_ptr_q] <= ram_rd_data;
          fifo_last_q[fifo_wr_ptr_q] <= rd_last_q;
          fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
        end
        if (fifo_pop) begin
          fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
        end
        fifo_cnt_q <= fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Testbench for ram_rd_stream: a behavioural RAM, a queue-based model of the
// expected beat sequence per command, and one compare process that checks
// every beat, stall stability, first-beat latency and done timing.
module tb_ram_rd_stream;

  localparam int Width    = 18;
  localparam int Depth    = 64;
  localparam int AddrBits = 6;

  typedef struct {
    logic [Width-1:0] d;
    logic             last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [AddrBits-1:0] start_addr = '0;
  logic [AddrBits:0]   length = '0;
  logic                busy;
  logic                done;
  logic [AddrBits-1:0] ram_rd_addr;
  logic [Width-1:0]    ram_rd_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [Width-1:0]    out_data;
  logic                out_last;
`ifdef RAM_RD_STREAM_ABORT_EN
  logic                abort = 1'b0;
`endif

  ram_rd_stream #(.Width(Width), .Depth(Depth)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RAM_RD_STREAM_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data for the address seen at an edge appears after it.
  logic [Width-1:0] mem [Depth];
  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state for the command in progress.
  beat_t            q[$];
  int               c0 = -1000;
  int               exp_done_cyc = -1;
  bit               first_pending = 0;
  int               last_hs = -1;
  bit               nobubble = 0;
  bit               cmd_finished = 0;
  int               beats = 0;
  int               done_cyc_seen = -1;
  logic [Width-1:0] beat_log [128];
  logic             last_log [128];
  int               beat_cyc [128];
  logic [AddrBits-1:0] addr_log [16];
  int               ready_mode = 0;
  int               stall_left = 0;

  // Ready generator: 0 = always ready, 1 = random, 2 = random with 5-cycle stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        out_ready  = 1'b1;
        stall_left = 0;
      end else if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (ready_mode == 2 && $urandom_range(0, 5) == 0) begin
        out_ready  = 1'b0;
        stall_left = 4;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Compare process: every cycle, checks DUT outputs against the model.
  initial begin
    bit               prev_stall = 0;
    logic [Width-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (cyc - c0 >= 0 && cyc - c0 < 16) addr_log[cyc - c0] = ram_rd_addr;
        if (done || cyc == exp_done_cyc) begin
          check("done_pulse", 32'(done), 32'(cyc == exp_done_cyc));
          if (done) begin
            check("done_after_all_beats", 32'(q.size()), 0);
            exp_done_cyc  = -1;
            done_cyc_seen = cyc;
            cmd_finished  = 1;
          end
        end
        if (out_valid) begin
          if (first_pending) begin
            check("first_beat_latency", cyc, c0 + 3);
            first_pending = 0;
          end
          if (prev_stall) begin
            check("stall_data_stable", out_data, prev_data);
            check("stall_last_stable", out_last, prev_last);
          end
          if (q.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else if (out_ready) begin
            check("beat_data", out_data, q[0].d);
            check("beat_last", out_last, q[0].last);
            if (nobubble && last_hs >= 0) check("no_bubble", cyc, last_hs + 1);
            last_hs = cyc;
            if (beats < 128) begin
              beat_log[beats] = out_data;
              last_log[beats] = out_last;
              beat_cyc[beats] = cyc;
            end
            beats++;
            if (q[0].last) exp_done_cyc = cyc + 1;
            void'(q.pop_front());
          end
        end else if (prev_stall) begin
          check("valid_dropped_without_handshake", out_valid, 1);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic start_cmd(input int addr, input int len, input int mode);
    int    n = 0;
    int    lc;
    beat_t b;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_before_start", busy, 0);
    ready_mode = mode;
    nobubble   = (mode == 0);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = addr[AddrBits-1:0];
    length     = len[AddrBits:0];
    lc = (len > Depth) ? Depth : len;
    q.delete();
    for (int i = 0; i < lc; i++) begin
      b.d    = mem[(addr + i) % Depth];
      b.last = (i == lc - 1);
      q.push_back(b);
    end
    c0            = cyc;
    first_pending = (lc != 0);
    last_hs       = -1;
    cmd_finished  = 0;
    beats         = 0;
    done_cyc_seen = -1;
    exp_done_cyc  = (lc == 0) ? c0 + 2 : -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done; optionally pulses an extra start at cycle c0+poke (must be ignored).
  task automatic finish_cmd(input int poke);
    for (int n = 0; n < 3000 && !cmd_finished; n++) begin
      @(posedge clk);
      #1;
      start = (poke > 0 && cyc == c0 + poke);
      if (start) begin
        start_addr = 6'd40;
        length     = 7'd3;
      end
    end
    if (start) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("cmd_completes", cmd_finished, 1);
    $display("cmd start_addr=%0d length=%0d beats=%0d done_offset=%0d",
             start_addr, length, beats, done_cyc_seen - c0);
  endtask

  task automatic run_cmd(input int addr, input int len, input int mode, input int poke);
    start_cmd(addr, len, mode);
    finish_cmd(poke);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = Width'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_ram_rd_addr", ram_rd_addr, 0);
    check("reset_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic: 5,6,7,8 back to back from T+3, done right after the last beat.
    run_cmd(5, 4, 0, 0);
    check("t1_beats", beats, 4);
    for (int i = 0; i < 4; i++) check("t1_data", beat_log[i], 5 + i);
    check("t1_last_on_8", last_log[3], 1);
    check("t1_no_last_on_7", last_log[2], 0);
    check("t1_first_cycle", beat_cyc[0], c0 + 3);
    check("t1_fourth_cycle", beat_cyc[3], c0 + 6);
    check("t1_done_cycle", done_cyc_seen, c0 + 7);
    check("t1_first_addr", addr_log[1], 5);

    // Address wrap 62,63,0,1.
    run_cmd(62, 4, 0, 0);
    check("wrap_addr0", addr_log[1], 62);
    check("wrap_addr1", addr_log[2], 63);
    check("wrap_addr2", addr_log[3], 0);
    check("wrap_addr3", addr_log[4], 1);
    check("wrap_data0", beat_log[0], 62);
    check("wrap_data1", beat_log[1], 63);
    check("wrap_data2", beat_log[2], 0);
    check("wrap_data3", beat_log[3], 1);

    // Backpressure with 5-cycle stalls.
    run_cmd(20, 8, 2, 0);
    check("stall_beats", beats, 8);

    // Zero length: no beats, done two cycles after start.
    run_cmd(9, 0, 0, 0);
    check("len0_beats", beats, 0);
    check("len0_done_cycle", done_cyc_seen, c0 + 2);

    // Over-length clamps to Depth.
    run_cmd(3, 100, 0, 0);
    check("clamp_beats", beats, 64);
    check("clamp_last_data", beat_log[63], 2);

    // Start in the done cycle is ignored.
    run_cmd(11, 0, 0, 2);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("start_in_done_ignored", busy, 0);

    // Start while busy is ignored.
    run_cmd(10, 6, 0, 3);
    check("busy_start_beats", beats, 6);

    // Reset after the third beat of a 10-word command.
    start_cmd(30, 10, 0);
    for (int n = 0; n < 50 && beats < 3; n++) begin
      @(posedge clk);
      #1;
    end
    check("reached_three_beats", 32'(beats >= 3), 1);
    rst = 1'b1;
    q.delete();
    exp_done_cyc  = -1;
    first_pending = 0;
    c0            = -1000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (8) @(posedge clk);
    #1;
    run_cmd(7, 5, 1, 0);
    check("after_rst_beats", beats, 5);

`ifdef RAM_RD_STREAM_ABORT_EN
    // Abort after two beats: the beat in the abort cycle is the last one.
    begin
      int a;
      start_cmd(0, 20, 0);
      for (int n = 0; n < 50 && beats < 2; n++) begin
        @(posedge clk);
        #1;
      end
      abort        = 1'b1;
      a            = cyc;
      exp_done_cyc = a + 2;
      @(posedge clk);
      #1;
      abort = 1'b0;
      q.delete();
      finish_cmd(0);
      check("abort_beats", beats, 3);
      check("abort_done_cycle", done_cyc_seen, a + 2);
    end
`endif

    // Randomized commands over random RAM contents.
    for (int i = 0; i < Depth; i++) mem[i] = Width'($urandom);
    for (int k = 0; k < 25; k++) begin
      int addr;
      int len;
      int mode;
      int lc;
      addr = $urandom_range(0, Depth - 1);
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      lc   = (len > Depth) ? Depth : len;
      run_cmd(addr, len, mode, 0);
      check("rand_beats", beats, lc);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
